// File: rtl/controle_reproducao.sv
`default_nettype none
// ============================================================================
// Module      : controle_reproducao
// Description : Playback controller for a multi-track audio player.
//               Handles play/pause, manual next/previous track selection and
//               automatic advance at end of track, and generates the sample
//               advance pulse (count) for the external address counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_HZ     : system clock frequency in Hz
//   SAMPLE_HZ  : address advance rate in Hz (DIV = CLK_HZ/SAMPLE_HZ, >= 2)
//   N_MUSICAS  : number of tracks in the playlist
// Ports
//   clk            in   system clock, all logic on rising edge
//   reset          in   synchronous active-high reset
//   play_pause     in   play/pause button level (synchronised, debounced)
//   proxima        in   next-track button level
//   anterior       in   previous-track button level
//   prox_musica    in   end-of-track flag from the address counter
//   count          out  one-cycle advance pulse to the address counter
//   reset_endereco out  one-cycle address counter restart pulse
//   musica_atual   out  current track index (upper address bits)
//   tocando        out  high while playing
// Configuration macro
//   REPETE_PLAYLIST_EN : when defined, end of the last track loops back to
//                        track 0 and keeps playing; otherwise playback stops.
// ============================================================================
module controle_reproducao #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SAMPLE_HZ = 3000,
  parameter int N_MUSICAS = 4,
  localparam int W        = (N_MUSICAS > 1) ? $clog2(N_MUSICAS) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         play_pause,
  input  logic         proxima,
  input  logic         anterior,
  input  logic         prox_musica,
  output logic         count,
  output logic         reset_endereco,
  output logic [W-1:0] musica_atual,
  output logic         tocando
);

  localparam int             DIV      = CLK_HZ / SAMPLE_HZ;
  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [W-1:0]   LAST     = W'(N_MUSICAS - 1);

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    TOCANDO = 2'd1,
    PAUSADO = 2'd2,
    TROCA   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  state_t          ret_state, ret_nxt;
  logic [W-1:0]    musica_nxt;
  logic [DW-1:0]   div_cnt, div_nxt;
  logic            pp_prev, prox_prev, ant_prev;
  logic            pp_press, prox_press, ant_press;

  assign pp_press   = play_pause & ~pp_prev;
  assign prox_press = proxima    & ~prox_prev;
  assign ant_press  = anterior   & ~ant_prev;

  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret_state;
    musica_nxt = musica_atual;

    // Divider advances only while playing, is frozen while paused and is
    // cleared in every other state.
    case (state)
      TOCANDO: div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      PAUSADO: div_nxt = div_cnt;
      default: div_nxt = '0;
    endcase

    if (state == TROCA) begin
      // Track change in progress: every input is ignored this cycle.
      state_nxt = ret_state;
    end else if (prox_press ^ ant_press) begin
      // Exactly one of next/previous; both together cancel each other and
      // fall through to the lower-priority events.
      ret_nxt   = state;
      state_nxt = TROCA;
      if (prox_press)
        musica_nxt = (musica_atual == LAST) ? '0 : musica_atual + 1'b1;
      else
        musica_nxt = (musica_atual == '0) ? LAST : musica_atual - 1'b1;
    end else if (prox_musica && (state == TOCANDO)) begin
      state_nxt = TROCA;
      if (musica_atual != LAST) begin
        musica_nxt = musica_atual + 1'b1;
        ret_nxt    = TOCANDO;
      end else begin
        musica_nxt = '0;
`ifdef REPETE_PLAYLIST_EN
        ret_nxt    = TOCANDO;
`else
        ret_nxt    = PARADO;
`endif
      end
    end else if (pp_press) begin
      case (state)
        PARADO:  state_nxt = TOCANDO;
        TOCANDO: state_nxt = PAUSADO;
        PAUSADO: state_nxt = TOCANDO;
        default: state_nxt = state;
      endcase
    end
  end

  // Outputs are derived from the next-state values so that they line up with
  // the state they describe: count is high exactly in the playing cycle in
  // which the divider sits at DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= PARADO;
      ret_state      <= PARADO;
      musica_atual   <= '0;
      div_cnt        <= '0;
      pp_prev        <= 1'b0;
      prox_prev      <= 1'b0;
      ant_prev       <= 1'b0;
      count          <= 1'b0;
      tocando        <= 1'b0;
      reset_endereco <= 1'b1;
    end else begin
      state          <= state_nxt;
      ret_state      <= ret_nxt;
      musica_atual   <= musica_nxt;
      div_cnt        <= div_nxt;
      pp_prev        <= play_pause;
      prox_prev      <= proxima;
      ant_prev       <= anterior;
      count          <= (state_nxt == TOCANDO) && (div_nxt == DIV_LAST);
      tocando        <= (state_nxt == TOCANDO);
      reset_endereco <= (state_nxt == TROCA);
    end
  end

endmodule
`default_nettype wire
